// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S scan controller.
// Holds the channel/result types, the FSM state encodings and the command-word builder.
package a2d_pkg;

    typedef logic [2:0]  ch_t;
    typedef logic [11:0] a2d_rslt_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        XFER,
        GAP
    } scan_state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_LEAD,
        SPI_LOW,
        SPI_HIGH
    } spi_state_t;

    localparam int NUM_CH     = 8;
    localparam int FRAME_BITS = 16;

    function automatic logic [15:0] mk_cmd(input ch_t ch);
        return {2'b00, ch, 11'b0};
    endfunction

    // Scans offsets 8 down to 1 so the smallest enabled offset wins; offset 8 is base itself.
    function automatic ch_t next_ch(input ch_t base, input logic [7:0] mask);
        ch_t pick;
        pick = base;
        for (int ofs = 8; ofs >= 1; ofs--) begin
            if (mask[base + ch_t'(ofs)]) begin
                pick = base + ch_t'(ofs);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master for the ADC128S: SCLK idles high, MOSI moves after falls,
// MISO is sampled on rises, done pulses together with SS_n rising.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] resp,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int DW = $clog2(SCLK_DIV);

    spi_state_t    state;
    spi_state_t    state_nxt;
    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [15:0]   tx_shft;
    logic          half_done;
    logic          last_bit;

    assign half_done = (div_cnt == DW'(SCLK_DIV - 1));
    assign last_bit  = (bit_cnt == 5'(FRAME_BITS));

    always_comb begin
        state_nxt = state;
        case (state)
            SPI_IDLE: if (start)     state_nxt = SPI_LEAD;
            SPI_LEAD: if (half_done) state_nxt = SPI_LOW;
            SPI_LOW:  if (half_done) state_nxt = SPI_HIGH;
            SPI_HIGH: if (half_done) state_nxt = last_bit ? SPI_IDLE : SPI_LOW;
            default:                 state_nxt = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SPI_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every half period ends in either a SCLK fall (shift out) or a rise (sample in).
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_shft <= '0;
            resp    <= '0;
            SS_n    <= 1'b1;
            SCLK    <= 1'b1;
            MOSI    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            div_cnt <= (state == SPI_IDLE || half_done) ? '0 : div_cnt + 1'b1;
            case (state)
                SPI_IDLE: begin
                    if (start) begin
                        SS_n    <= 1'b0;
                        tx_shft <= cmd;
                        bit_cnt <= '0;
                    end
                end
                SPI_LEAD: begin
                    if (half_done) begin
                        SCLK    <= 1'b0;
                        MOSI    <= tx_shft[15];
                        tx_shft <= {tx_shft[14:0], 1'b0};
                    end
                end
                SPI_LOW: begin
                    if (half_done) begin
                        SCLK    <= 1'b1;
                        resp    <= {resp[14:0], MISO};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                SPI_HIGH: begin
                    if (half_done) begin
                        if (last_bit) begin
                            SS_n <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            SCLK    <= 1'b0;
                            MOSI    <= tx_shft[15];
                            tx_shft <= {tx_shft[14:0], 1'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/a2d_scan_ctrl.sv
// Autonomous round-robin scan controller for the ADC128S. Results arrive one frame
// late, so each response is filed under the channel addressed by the previous frame.
module a2d_scan_ctrl
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV   = 16,
    parameter int PERIOD_CYC = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [7:0]  ch_mask,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        rslt_vld,
    output logic [2:0]  rslt_ch,
    output logic [11:0] rslt,
    output logic        busy,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int TW = $clog2(PERIOD_CYC);

    scan_state_t state;
    scan_state_t state_nxt;
    ch_t         cur_ch;
    ch_t         launch_ch;
    ch_t         sel_ch;
    logic        primed;
    logic        flush;
    logic [TW-1:0] timer;
    a2d_rslt_t   bank [NUM_CH];

    logic        spi_start;
    logic        spi_done;
    logic [15:0] spi_resp;
    logic        resp_unused;
    logic        scan_req;
    logic        period_up;

    assign scan_req    = scan_en && (ch_mask != 8'h00);
    assign period_up   = (timer == TW'(PERIOD_CYC - 1));
    assign resp_unused = ^spi_resp[15:12];

    // An unprimed scan searches from CH7 so the lowest enabled channel is picked first.
    assign sel_ch    = flush ? cur_ch : next_ch(primed ? cur_ch : ch_t'(7), ch_mask);
    assign spi_start = (state == START);

    spi_mstr16 #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk   (clk),
        .rst   (rst),
        .start (spi_start),
        .cmd   (mk_cmd(sel_ch)),
        .done  (spi_done),
        .resp  (spi_resp),
        .SS_n  (SS_n),
        .SCLK  (SCLK),
        .MOSI  (MOSI),
        .MISO  (MISO)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (scan_req) state_nxt = START;
            START: state_nxt = XFER;
            XFER:  if (spi_done) state_nxt = flush ? IDLE : GAP;
            GAP: begin
                if (period_up) begin
                    state_nxt = (scan_req || primed) ? START : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The timer counts from the START cycle, so frame starts are exactly PERIOD_CYC apart.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch    <= '0;
            launch_ch <= '0;
            primed    <= 1'b0;
            flush     <= 1'b0;
            timer     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            if (state == START) begin
                timer     <= TW'(1);
                launch_ch <= sel_ch;
            end else if (!period_up) begin
                timer <= timer + 1'b1;
            end

            if (state == XFER && spi_done) begin
                if (primed) begin
                    bank[cur_ch] <= spi_resp[11:0];
                end
                cur_ch <= launch_ch;
                primed <= !flush;
                flush  <= 1'b0;
            end

            if (state == GAP && period_up && !scan_req && primed) begin
                flush <= 1'b1;
            end
        end
    end

    assign rslt_vld = (state == XFER) && spi_done && primed;
    assign rslt_ch  = cur_ch;
    assign rslt     = spi_resp[11:0];
    assign busy     = (state != IDLE);
    assign rd_data  = bank[rd_ch];

endmodule
